// File: rtl/apb_multi_slave_fabric.sv
// APB4 one-to-N fabric: decodes the upstream address into a one-hot slave select,
// replays SETUP/ACCESS downstream with a time-out, and returns one RESP cycle upstream.
module apb_multi_slave_fabric #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_SLAVES     = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h4000_0000,
  parameter int                    SLV_ADDR_BITS  = 12,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                             pclk,
  input  logic                             presetn,
  input  logic                             s_psel,
  input  logic                             s_penable,
  input  logic                             s_pwrite,
  input  logic [ADDR_WIDTH-1:0]            s_paddr,
  input  logic [DATA_WIDTH-1:0]            s_pwdata,
  input  logic [DATA_WIDTH/8-1:0]          s_pstrb,
  input  logic [2:0]                       s_pprot,
  output logic                             s_pready,
  output logic [DATA_WIDTH-1:0]            s_prdata,
  output logic                             s_pslverr,
  output logic [NUM_SLAVES-1:0]            m_psel,
  output logic                             m_penable,
  output logic                             m_pwrite,
  output logic [ADDR_WIDTH-1:0]            m_paddr,
  output logic [DATA_WIDTH-1:0]            m_pwdata,
  output logic [DATA_WIDTH/8-1:0]          m_pstrb,
  output logic [2:0]                       m_pprot,
  input  logic [NUM_SLAVES-1:0]            m_pready,
  input  logic [NUM_SLAVES-1:0]            m_pslverr,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_prdata,
  output logic                             timeout_evt,
  output logic                             decode_err_evt
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    (ADDR_WIDTH'(1) << SLV_ADDR_BITS) - ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, M_SETUP, M_ACCESS, RESP} state_t;

  state_t                  r_state, w_nxt;
  logic [IDX_W-1:0]        r_idx, w_idx_sel;
  logic [CNT_W-1:0]        r_cnt;
  logic [NUM_SLAVES-1:0]   r_m_psel;
  logic                    r_m_penable, r_m_pwrite;
  logic [ADDR_WIDTH-1:0]   r_m_paddr;
  logic [DATA_WIDTH-1:0]   r_m_pwdata, r_rdata;
  logic [STRB_W-1:0]       r_m_pstrb;
  logic [2:0]              r_m_pprot;
  logic                    r_s_pready, r_s_pslverr, r_timeout_evt, r_dec_evt;

  logic [ADDR_WIDTH-1:0]   w_off, w_idx_full;
  logic                    w_setup, w_hit, w_timeout_hit;
  logic                    w_sel_ready, w_sel_err;
  logic [DATA_WIDTH-1:0]   w_sel_rdata;
  logic                    w_nxt_err, w_abort, w_miss, w_rd_load;

  // Decode works on the live upstream address; it is only consumed in IDLE.
  assign w_setup    = s_psel & ~s_penable;
  assign w_off      = s_paddr - BASE_ADDR;
  assign w_idx_full = w_off >> SLV_ADDR_BITS;
  assign w_hit      = (s_paddr >= BASE_ADDR) && (w_idx_full < ADDR_WIDTH'(NUM_SLAVES));
  assign w_idx_sel  = (r_state == IDLE) ? w_idx_full[IDX_W-1:0] : r_idx;

  // Only the latched target's response is ever observed.
  assign w_sel_ready   = m_pready[r_idx];
  assign w_sel_err     = m_pslverr[r_idx];
  assign w_sel_rdata   = m_prdata[r_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_nxt     = r_state;
    w_nxt_err = 1'b0;
    w_abort   = 1'b0;
    w_miss    = 1'b0;
    w_rd_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_setup) begin
          if (w_hit) begin
            w_nxt = M_SETUP;
          end else begin
            w_nxt     = RESP;
            w_nxt_err = 1'b1;
            w_miss    = 1'b1;
          end
        end
      end
      M_SETUP: w_nxt = M_ACCESS;
      M_ACCESS: begin
        // A ready on the limit cycle still counts as a normal completion.
        if (w_sel_ready) begin
          w_nxt     = RESP;
          w_nxt_err = w_sel_err;
          w_rd_load = ~r_m_pwrite & ~w_sel_err;
        end else if (w_timeout_hit) begin
          w_nxt     = RESP;
          w_nxt_err = 1'b1;
          w_abort   = 1'b1;
        end
      end
      RESP:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_m_psel      <= '0;
      r_m_penable   <= 1'b0;
      r_m_pwrite    <= 1'b0;
      r_m_paddr     <= '0;
      r_m_pwdata    <= '0;
      r_m_pstrb     <= '0;
      r_m_pprot     <= '0;
      r_rdata       <= '0;
      r_s_pready    <= 1'b0;
      r_s_pslverr   <= 1'b0;
      r_timeout_evt <= 1'b0;
      r_dec_evt     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == IDLE && w_setup) begin
        r_idx      <= w_idx_full[IDX_W-1:0];
        r_m_paddr  <= w_off & OFF_MASK;
        r_m_pwrite <= s_pwrite;
        r_m_pwdata <= s_pwdata;
        r_m_pstrb  <= s_pwrite ? s_pstrb : '0;
        r_m_pprot  <= s_pprot;
      end
      // Control outputs are registered from the next state so they line up with it.
      r_m_psel      <= (w_nxt == M_SETUP || w_nxt == M_ACCESS) ?
                       (NUM_SLAVES'(1) << w_idx_sel) : '0;
      r_m_penable   <= (w_nxt == M_ACCESS);
      r_cnt         <= (r_state == M_ACCESS && w_nxt == M_ACCESS) ? r_cnt + CNT_W'(1) : '0;
      r_s_pready    <= (w_nxt == RESP);
      r_s_pslverr   <= w_nxt_err;
      r_timeout_evt <= w_abort;
      r_dec_evt     <= w_miss;
      if (w_rd_load) r_rdata <= w_sel_rdata;
    end
  end

  assign s_pready       = r_s_pready;
  assign s_pslverr      = r_s_pslverr;
  assign s_prdata       = r_rdata;
  assign m_psel         = r_m_psel;
  assign m_penable      = r_m_penable;
  assign m_pwrite       = r_m_pwrite;
  assign m_paddr        = r_m_paddr;
  assign m_pwdata       = r_m_pwdata;
  assign m_pstrb        = r_m_pstrb;
  assign m_pprot        = r_m_pprot;
  assign timeout_evt    = r_timeout_evt;
  assign decode_err_evt = r_dec_evt;

endmodule

// File: tb/tb_apb_multi_slave_fabric.sv
// Randomized bench for apb_multi_slave_fabric: transaction-level model predicts
// latency, error, routing and retained read data for each upstream transfer.
module tb_apb_multi_slave_fabric;
  localparam int AW = 32, DW = 32, NS = 4, SAB = 12, TO = 16;
  localparam longint BASE = 64'h4000_0000;

  logic               pclk, presetn;
  logic               s_psel, s_penable, s_pwrite;
  logic [AW-1:0]      s_paddr;
  logic [DW-1:0]      s_pwdata;
  logic [DW/8-1:0]    s_pstrb;
  logic [2:0]         s_pprot;
  logic               s_pready, s_pslverr;
  logic [DW-1:0]      s_prdata;
  logic [NS-1:0]      m_psel;
  logic               m_penable, m_pwrite;
  logic [AW-1:0]      m_paddr;
  logic [DW-1:0]      m_pwdata;
  logic [DW/8-1:0]    m_pstrb;
  logic [2:0]         m_pprot;
  logic [NS-1:0]      m_pready, m_pslverr;
  logic [NS*DW-1:0]   m_prdata;
  logic               timeout_evt, decode_err_evt;

  apb_multi_slave_fabric #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .BASE_ADDR(32'h4000_0000),
    .SLV_ADDR_BITS(SAB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite), .s_paddr(s_paddr),
    .s_pwdata(s_pwdata), .s_pstrb(s_pstrb), .s_pprot(s_pprot),
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
    .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pprot(m_pprot),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata),
    .timeout_evt(timeout_evt), .decode_err_evt(decode_err_evt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] mdl_rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Non-selected slaves babble random responses; the target gets the scripted ones.
  task automatic drive_slaves(input int idx, input bit rdy, input bit err, input logic [DW-1:0] rd);
    for (int i = 0; i < NS; i++) begin
      m_pready[i]            = 1'($urandom_range(0, 1));
      m_pslverr[i]           = 1'($urandom_range(0, 1));
      m_prdata[i*DW +: DW]   = $urandom;
    end
    if (idx >= 0) begin
      m_pready[idx]          = rdy;
      m_pslverr[idx]         = err;
      m_prdata[idx*DW +: DW] = rd;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s"}, {s_pready, s_pslverr, s_prdata}, 0);
    chk({tag, "_mctl"}, {m_psel, m_penable, m_pwrite, m_pprot, m_pstrb}, 0);
    chk({tag, "_maddr"}, m_paddr, 0);
    chk({tag, "_mwdata"}, m_pwdata, 0);
    chk({tag, "_evt"}, {timeout_evt, decode_err_evt}, 0);
  endtask

  // Called at a negedge in an IDLE cycle; returns at a negedge of the following IDLE cycle.
  // waits = slave wait cycles before m_pready (>= TO means the slave never answers in time).
  task automatic xfer(input logic [AW-1:0] addr, input bit wr, input logic [DW-1:0] wd,
                      input logic [3:0] strb, input logic [2:0] prot, input int waits,
                      input bit serr, input logic [DW-1:0] rd);
    longint al, off;
    bit hit, exp_err, exp_to, done, seen_sel, rdy;
    int idx, exp_lat, cyc, a, n_to, n_de, bad_sel;
    logic [NS-1:0] exp_sel;
    al  = longint'(addr);
    off = al - BASE;
    hit = (al >= BASE) && ((off / (64'd1 << SAB)) < NS);
    idx = hit ? int'(off / (64'd1 << SAB)) : -1;
    exp_sel = hit ? NS'(1 << idx) : '0;
    exp_to = 1'b0;
    if (!hit)             begin exp_lat = 1;          exp_err = 1'b1; end
    else if (waits < TO)  begin exp_lat = 3 + waits;  exp_err = serr; end
    else                  begin exp_lat = 2 + TO;     exp_err = 1'b1; exp_to = 1'b1; end

    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr; s_paddr = addr;
    s_pwdata = wd; s_pstrb = strb; s_pprot = prot;
    drive_slaves(idx, 1'b0, serr, rd);
    cyc = 0; a = 0; n_to = 0; n_de = 0; bad_sel = 0; done = 0; seen_sel = 0;
    while (!done && cyc < 60) begin
      @(negedge pclk);
      cyc++;
      s_penable = 1'b1;
      s_paddr   = $urandom;  // late upstream changes must be ignored
      if (timeout_evt) n_to++;
      if (decode_err_evt) n_de++;
      if (m_psel != 0 && m_psel != exp_sel) bad_sel++;
      if (hit && m_psel != 0 && !seen_sel) begin
        seen_sel = 1'b1;
        chk("setup_cycle", cyc, 1);
        chk("setup_penable", m_penable, 0);
        chk("m_paddr", m_paddr, off % (64'd1 << SAB));
        chk("m_pwrite", m_pwrite, wr);
        chk("m_pwdata", m_pwdata, wd);
        chk("m_pstrb", m_pstrb, wr ? strb : 4'b0);
        chk("m_pprot", m_pprot, prot);
      end
      if (s_pready) begin
        done = 1'b1;
        chk("latency", cyc, exp_lat);
        chk("s_pslverr", s_pslverr, exp_err);
        if (hit && waits < TO && !wr && !serr) mdl_rdata = rd;
        chk("s_prdata", s_prdata, mdl_rdata);
        chk("resp_psel", m_psel, 0);
        s_psel = 1'b0; s_penable = 1'b0;
        drive_slaves(-1, 1'b0, 1'b0, '0);
      end else begin
        rdy = 1'b0;
        if (hit && m_penable && m_psel == exp_sel) begin
          rdy = (a == waits);
          a++;
        end
        drive_slaves(idx, rdy, serr, rd);
      end
    end
    if (!done) begin
      chk("pready_wait", cyc, exp_lat);
      s_psel = 1'b0; s_penable = 1'b0;
    end
    chk("psel_route", bad_sel, 0);
    if (hit) chk("psel_seen", seen_sel, 1);
    chk("timeout_evt_cnt", n_to, exp_to);
    chk("decode_evt_cnt", n_de, !hit);
    @(negedge pclk);
    chk("pready_one_cycle", s_pready, 0);
    chk("evt_clear", {timeout_evt, decode_err_evt}, 0);
  endtask

  initial begin
    logic [AW-1:0] ra;
    int sel, w;
    presetn = 1'b0; s_psel = 0; s_penable = 0; s_pwrite = 0; s_paddr = '0;
    s_pwdata = '0; s_pstrb = '0; s_pprot = '0;
    m_pready = '0; m_pslverr = '0; m_prdata = '0;
    mdl_rdata = '0;
    #12;
    chk_all_zero("reset");
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);

    xfer(32'h4000_2010, 1'b0, 32'h0,         4'hF,    3'd0, 0,  1'b0, 32'hA5A5_0001);
    xfer(32'h4000_3004, 1'b1, 32'h1234_5678, 4'b0011, 3'd2, 3,  1'b0, 32'hDEAD_BEEF);
    xfer(32'h4000_4000, 1'b0, 32'h0,         4'hF,    3'd0, 0,  1'b0, 32'h1111_1111);
    xfer(32'h3FFF_FFFC, 1'b1, 32'hCAFE_0000, 4'hF,    3'd1, 0,  1'b0, 32'h2222_2222);
    xfer(32'h4000_1000, 1'b0, 32'h0,         4'hF,    3'd0, 99, 1'b0, 32'h3333_3333);
    xfer(32'h4000_1ffc, 1'b0, 32'h0,         4'hF,    3'd0, TO - 1, 1'b0, 32'h5A5A_1234);
    xfer(32'h4000_0008, 1'b0, 32'h0,         4'hF,    3'd0, 1,  1'b1, 32'h4444_4444);
    xfer(32'h4000_2010, 1'b0, 32'h0,         4'hF,    3'd0, 0,  1'b0, 32'hA5A5_0001);

    // Reset during M_ACCESS: everything clears at once and no RESP follows.
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b0; s_paddr = 32'h4000_1020;
    drive_slaves(1, 1'b0, 1'b0, 32'h7777_7777);
    @(negedge pclk); s_penable = 1'b1; drive_slaves(1, 1'b0, 1'b0, 32'h7777_7777);
    @(negedge pclk); drive_slaves(1, 1'b0, 1'b0, 32'h7777_7777);
    chk("pre_rst_access", {m_penable, m_psel}, {1'b1, 4'b0010});
    #2 presetn = 1'b0;
    #1 chk_all_zero("mid_rst");
    s_psel = 1'b0; s_penable = 1'b0;
    mdl_rdata = '0;
    @(negedge pclk); presetn = 1'b1;
    @(negedge pclk);
    chk("rst_no_resp", s_pready, 0);
    xfer(32'h4000_0100, 1'b0, 32'h0, 4'hF, 3'd0, 2, 1'b0, 32'h0BAD_F00D);

    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      ra = 32'(BASE - 4 * longint'($urandom_range(1, 1000)));
      else if (sel == 1) ra = 32'(BASE + (NS << SAB) + longint'($urandom_range(0, 'hFFFF)));
      else               ra = 32'(BASE + ($urandom_range(0, NS - 1) << SAB) + ($urandom_range(0, 1023) << 2));
      sel = $urandom_range(0, 9);
      if (sel < 7)       w = $urandom_range(0, 4);
      else if (sel == 7) w = TO - 1;
      else if (sel == 8) w = TO;
      else               w = 99;
      xfer(ra, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), w, ($urandom_range(0, 4) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
